axi_line_master: RTL

AXI_LINE_MASTER -- requirements
Module: axi_line_master

---
 rtl/axi_line_master_if.sv | 36 +++
 rtl/axi_line_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master_if.sv
// rtl/axi_line_master_if.sv - AXI read/write channel bundle between axi_line_master and its slave
interface axi_line_master_if;
    logic [15:0]  arid_o;
    logic [63:0]  araddr_o;
    logic         arvalid_o;
    logic         arready_i;
    logic [15:0]  rid_i;
    logic [575:0] rdata_i;
    logic         rvalid_i;
    logic         rready_o;
    logic [15:0]  awid_o;
    logic [63:0]  awaddr_o;
    logic         awvalid_o;
    logic         awready_i;
    logic [15:0]  wid_o;
    logic [511:0] wdata_o;
    logic         wvalid_o;
    logic         wready_i;
    logic [15:0]  bid_i;
    logic         bvalid_i;
    logic         bready_o;

    modport master (
        output arid_o, araddr_o, arvalid_o, rready_o,
        output awid_o, awaddr_o, awvalid_o, wid_o, wdata_o, wvalid_o, bready_o,
        input  arready_i, rid_i, rdata_i, rvalid_i,
        input  awready_i, wready_i, bid_i, bvalid_i
    );

    modport slave (
        input  arid_o, araddr_o, arvalid_o, rready_o,
        input  awid_o, awaddr_o, awvalid_o, wid_o, wdata_o, wvalid_o, bready_o,
        output arready_i, rid_i, rdata_i, rvalid_i,
        output awready_i, wready_i, bid_i, bvalid_i
    );
endinterface

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - single-outstanding 64-byte line read/write master over AXI
// Optional watchdog enabled by defining AXI_LINE_MASTER_TIMEOUT_EN.
module axi_line_master #(
    parameter logic [15:0] ID          = 16'd1,
    parameter logic [15:0] TIMEOUT_CYC = 16'd256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [63:0]           req_addr_i,
    input  logic [511:0]          req_wdata_i,
    output logic                  resp_valid_o,
    output logic [575:0]          resp_data_o,
    output logic                  resp_err_o,
    axi_line_master_if.master     axi
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_write, w_write_nxt;
    logic [63:0]    r_addr, w_addr_nxt;
    logic [511:0]   r_wdata, w_wdata_nxt;
    logic [575:0]   r_rdata, w_rdata_nxt;
    logic           r_err, w_err_nxt;
    logic           r_req_ready, w_req_ready_nxt;
    logic           r_arvalid, w_arvalid_nxt;
    logic           r_rready, w_rready_nxt;
    logic           r_awvalid, w_awvalid_nxt;
    logic           r_wvalid, w_wvalid_nxt;
    logic           r_bready, w_bready_nxt;
    logic           r_aw_done, w_aw_done_nxt;
    logic           r_w_done, w_w_done_nxt;
    logic           w_accept;
    logic           w_aw_hs;
    logic           w_w_hs;
    logic           w_timeout;

    assign w_accept = (r_state == S_IDLE) && req_valid_i && r_req_ready;

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        w_busy;

    assign w_busy    = (r_state == S_AR) || (r_state == S_R) ||
                       (r_state == S_AWW) || (r_state == S_B);
    // Fires on the edge where the count would reach TIMEOUT_CYC.
    assign w_timeout = w_busy && (r_cnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (w_accept) begin
            r_cnt <= 16'd0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    logic w_unused;
    assign w_unused = ^req_addr_i[5:0];
`else
    assign w_timeout = 1'b0;

    logic w_unused;
    assign w_unused = ^{req_addr_i[5:0], TIMEOUT_CYC};
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_write_nxt   = r_write;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rdata_nxt   = r_rdata;
        w_err_nxt     = r_err;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_aw_hs       = r_awvalid && axi.awready_i;
        w_w_hs        = r_wvalid && axi.wready_i;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_write_nxt   = req_write_i;
                    w_addr_nxt    = {req_addr_i[63:6], 6'b0};
                    w_wdata_nxt   = req_wdata_i;
                    w_rdata_nxt   = '0;
                    w_err_nxt     = 1'b0;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_arvalid_nxt = !req_write_i;
                    w_awvalid_nxt = req_write_i;
                    w_wvalid_nxt  = req_write_i;
                    w_state_nxt   = req_write_i ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                if (r_arvalid && axi.arready_i) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_R;
                end
            end
            S_R: begin
                if (r_rready && axi.rvalid_i) begin
                    w_rdata_nxt  = axi.rdata_i;
                    w_err_nxt    = (axi.rid_i != ID);
                    w_rready_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end
            end
            S_AWW: begin
                // AW and W complete independently; B is entered once both have.
                w_awvalid_nxt = r_awvalid && !w_aw_hs;
                w_wvalid_nxt  = r_wvalid && !w_w_hs;
                w_aw_done_nxt = r_aw_done || w_aw_hs;
                w_w_done_nxt  = r_w_done || w_w_hs;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_B;
                end
            end
            S_B: begin
                if (r_bready && axi.bvalid_i) begin
                    w_err_nxt    = (axi.bid_i != ID);
                    w_bready_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_timeout) begin
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_rdata_nxt   = '0;
            w_err_nxt     = 1'b1;
            w_state_nxt   = S_DONE;
        end

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
        end
    end

    assign req_ready_o  = r_req_ready;
    assign resp_valid_o = (r_state == S_DONE);
    assign resp_err_o   = (r_state == S_DONE) && r_err;
    assign resp_data_o  = ((r_state == S_DONE) && !r_write) ? r_rdata : '0;

    assign axi.arid_o    = ID;
    assign axi.araddr_o  = r_addr;
    assign axi.arvalid_o = r_arvalid;
    assign axi.rready_o  = r_rready;
    assign axi.awid_o    = ID;
    assign axi.awaddr_o  = r_addr;
    assign axi.awvalid_o = r_awvalid;
    assign axi.wid_o     = ID;
    assign axi.wdata_o   = r_wdata;
    assign axi.wvalid_o  = r_wvalid;
    assign axi.bready_o  = r_bready;

endmodule
